ps2_letter_decoder: RTL

PS2_LETTER_DECODER -- requirements
Module: ps2_letter_decoder

---
 rtl/ps2_letter_decoder_pkg.sv | 47 ++++
 rtl/ps2_letter_decoder_frame_rx.sv | 83 ++++++++
 rtl/ps2_letter_decoder.sv | 60 ++++++
 3 files changed

// File: rtl/ps2_letter_decoder_pkg.sv
// ps2_letter_decoder_pkg: scan-code constants, FSM encodings and set-2 letter translation.
package ps2_letter_decoder_pkg;

    localparam logic [7:0] SC_BREAK   = 8'hF0;
    localparam logic [7:0] SC_EXT     = 8'hE0;
    localparam logic [4:0] CHAR_ENTER = 5'd27;
    localparam logic [4:0] CHAR_BKSP  = 5'd28;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;
    typedef enum logic [1:0] {NORMAL, BREAK, EXT, EXT_BREAK} dec_state_t;

    // Returns 0 for any scan code that has no character.
    function automatic logic [4:0] scan_to_char(input logic [7:0] sc);
        case (sc)
            8'h1C: scan_to_char = 5'd1;
            8'h32: scan_to_char = 5'd2;
            8'h21: scan_to_char = 5'd3;
            8'h23: scan_to_char = 5'd4;
            8'h24: scan_to_char = 5'd5;
            8'h2B: scan_to_char = 5'd6;
            8'h34: scan_to_char = 5'd7;
            8'h33: scan_to_char = 5'd8;
            8'h43: scan_to_char = 5'd9;
            8'h3B: scan_to_char = 5'd10;
            8'h42: scan_to_char = 5'd11;
            8'h4B: scan_to_char = 5'd12;
            8'h3A: scan_to_char = 5'd13;
            8'h31: scan_to_char = 5'd14;
            8'h44: scan_to_char = 5'd15;
            8'h4D: scan_to_char = 5'd16;
            8'h15: scan_to_char = 5'd17;
            8'h2D: scan_to_char = 5'd18;
            8'h1B: scan_to_char = 5'd19;
            8'h2C: scan_to_char = 5'd20;
            8'h3C: scan_to_char = 5'd21;
            8'h2A: scan_to_char = 5'd22;
            8'h1D: scan_to_char = 5'd23;
            8'h22: scan_to_char = 5'd24;
            8'h35: scan_to_char = 5'd25;
            8'h1A: scan_to_char = 5'd26;
            8'h5A: scan_to_char = CHAR_ENTER;
            8'h66: scan_to_char = CHAR_BKSP;
            default: scan_to_char = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/ps2_letter_decoder_frame_rx.sv
// ps2_frame_rx: synchronizes the PS/2 lines and assembles 11-bit frames into bytes.
module ps2_frame_rx
    import ps2_letter_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       err_frame
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_prev;
    logic          fall;
    logic          dat;
    rx_state_t     state;
    logic [2:0]    bit_cnt;
    logic [TW-1:0] idle_cnt;
    logic          parity_ok;

    assign fall = clk_prev & ~clk_sync[1];
    assign dat  = dat_sync[1];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_sync   <= 2'b11;
            dat_sync   <= 2'b11;
            clk_prev   <= 1'b1;
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            rx_byte    <= 8'd0;
            idle_cnt   <= '0;
            parity_ok  <= 1'b0;
            byte_valid <= 1'b0;
            err_frame  <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk};
            dat_sync   <= {dat_sync[0], ps2_dat};
            clk_prev   <= clk_sync[1];
            byte_valid <= 1'b0;
            err_frame  <= 1'b0;
            if (fall) begin
                idle_cnt <= '0;
                case (state)
                    IDLE: if (!dat) begin
                        state   <= DATA;
                        bit_cnt <= 3'd0;
                    end
                    DATA: begin
                        rx_byte <= {dat, rx_byte[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        parity_ok <= ^{rx_byte, dat};
                        state     <= STOP;
                    end
                    STOP: begin
                        byte_valid <= dat & parity_ok;
                        err_frame  <= ~(dat & parity_ok);
                        state      <= IDLE;
                    end
                endcase
            end else if (state != IDLE) begin
                // A stalled keyboard abandons the frame quietly.
                if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    state    <= IDLE;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + TW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ps2_letter_decoder.sv
// ps2_letter_decoder: PS/2 keyboard to letter/enter/backspace codes with a valid/ack handshake.
module ps2_letter_decoder
    import ps2_letter_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [4:0] char,
    output logic       char_valid,
    input  logic       char_ack,
    output logic       err_frame,
    output logic       err_overflow
);

    logic [7:0] rx_byte;
    logic       byte_valid;
    dec_state_t dstate;
    logic [4:0] code;
    logic       new_code;
    logic       accept;

    ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clk       (clk),
        .resetn    (resetn),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .err_frame (err_frame)
    );

    assign code     = scan_to_char(rx_byte);
    assign new_code = byte_valid && dstate == NORMAL && code != 5'd0;
    assign accept   = char_valid & char_ack;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dstate       <= NORMAL;
            char         <= 5'd0;
            char_valid   <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            if (byte_valid)
                dstate <= dstate == NORMAL ? (rx_byte == SC_BREAK ? BREAK : rx_byte == SC_EXT ? EXT : NORMAL)
                        : (dstate == EXT && rx_byte == SC_BREAK) ? EXT_BREAK : NORMAL;
            // An accept on the same edge frees the slot for the incoming code.
            if (new_code && (!char_valid || accept)) begin
                char       <= code;
                char_valid <= 1'b1;
            end else if (accept) begin
                char_valid <= 1'b0;
            end
            if (new_code && char_valid && !accept) err_overflow <= 1'b1;
        end
    end

endmodule
